pow_n_pipelined_ready_valid: RTL and testbench

Parametrised pipelined integer power unit. It computes `in_data ** n_pow` over `n_pow-1` multiply stages. It carries a per-stage valid bit and a full valid/ready handshake on both sides, so it stalls under downstream backpressure without losing or duplicating data. It is the next generation of the fixed x^5 valid-only pipeline in the microarchitecture labs. It sits between a switch/key producer and a consumer such as the seven-segment display or a FIFO.

---
 rtl/pow_n_pipelined_ready_valid.sv | 99 +++++++++
 tb/tb_pow_n_pipelined_ready_valid.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pow_n_pipelined_ready_valid.sv
// Pipelined unsigned integer power x**n_pow with valid/ready handshakes on both sides.
// Bubbles collapse: each stage accepts whenever any stage at or downstream of it is empty.
module pow_n_pipelined_ready_valid #(
  parameter int w_data   = 8,
  parameter int n_pow    = 5,
  parameter int w_result = n_pow * w_data,
  parameter int w_occ    = $clog2(n_pow)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [w_data-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [w_result-1:0] out_data,
  output logic [w_occ-1:0]    occupancy
);

  localparam int STAGES = n_pow - 1;
  localparam int PAD    = w_result - w_data;

  logic [STAGES:1]     valid_q, valid_d;
  logic [STAGES:1]     ready;
  logic [STAGES:1]     vin;
  logic [STAGES:1]     load;
  logic [w_data-1:0]   x_q [1:STAGES];
  logic [w_data-1:0]   x_d [1:STAGES];
  logic [w_result-1:0] p_q [1:STAGES];
  logic [w_result-1:0] p_d [1:STAGES];
  logic [w_occ-1:0]    occ_q, occ_d;
  logic [w_result-1:0] in_ext;
  logic                in_hs, out_hs;

  // A stage can advance if it or any stage downstream has a free slot, or the consumer takes the head.
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      ready[k] = out_ready;
      for (int j = k; j <= STAGES; j++) begin
        if (!valid_q[j]) ready[k] = 1'b1;
      end
    end
  end

  assign in_ext = {{PAD{1'b0}}, in_data};

  always_comb begin
    vin[1] = in_valid;
    x_d[1] = in_data;
    p_d[1] = in_ext * in_ext;
    for (int k = 2; k <= STAGES; k++) begin
      vin[k] = valid_q[k-1];
      x_d[k] = x_q[k-1];
      p_d[k] = {{PAD{1'b0}}, x_q[k-1]} * p_q[k-1];
    end
    for (int k = 1; k <= STAGES; k++) begin
      load[k]    = ready[k] & vin[k];
      valid_d[k] = ready[k] ? vin[k] : valid_q[k];
    end
  end

  assign in_hs  = in_valid & ready[1];
  assign out_hs = valid_q[STAGES] & out_ready;

  always_comb begin
    case ({in_hs, out_hs})
      2'b10:   occ_d = occ_q + w_occ'(1);
      2'b01:   occ_d = occ_q - w_occ'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state: valid chain and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Datapath registers: loaded only when a valid item moves in, never reset.
  always_ff @(posedge clk) begin
    for (int k = 1; k <= STAGES; k++) begin
      if (load[k]) begin
        x_q[k] <= x_d[k];
        p_q[k] <= p_d[k];
      end
    end
  end

  assign in_ready  = ready[1];
  assign out_valid = valid_q[STAGES];
  assign out_data  = p_q[STAGES];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pow_n_pipelined_ready_valid.sv
// Directed and randomised bench for pow_n_pipelined_ready_valid (n_pow=5/w_data=8 and n_pow=2/w_data=4).
module tb_pow_n_pipelined_ready_valid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [39:0] out_data;
  logic [2:0]  occupancy;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [3:0]  c_in_data;
  logic [7:0]  c_out_data;
  logic [0:0]  c_occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pow_n_pipelined_ready_valid #(.w_data(8), .n_pow(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pow_n_pipelined_ready_valid #(.w_data(4), .n_pow(2)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occupancy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pow5(input logic [7:0] x);
    logic [39:0] r;
    r = 40'd1;
    for (int i = 0; i < 5; i++) r = r * {32'd0, x};
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_c_out_valid got %0b want 0", c_out_valid); end
    n_cmp++; if (c_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_c_in_ready got %0b want 1", c_in_ready); end
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_single;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd3;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready got %0b want 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      tick;
      if (i == 0) in_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== (i == 3)) begin n_err++; $display("FAIL single_out_valid edge %0d got %0b want %0b", i, out_valid, (i == 3)); end
      n_cmp++; if (occupancy !== ((i < 4) ? 3'd1 : 3'd0)) begin n_err++; $display("FAIL single_occupancy edge %0d got %0d", i, occupancy); end
      if (i == 3) begin
        n_cmp++; if (out_data !== 40'd243) begin n_err++; $display("FAIL single_out_data got %0d want 243", out_data); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  vals [4];
    logic [39:0] exp  [4];
    vals = '{8'd1, 8'd2, 8'd3, 8'd255};
    exp  = '{40'd1, 40'd32, 40'd243, 40'd1078203909375};
    out_ready = 1'b1; in_valid = 1'b1; in_data = vals[0];
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready_0 got %0b want 1", in_ready); end
    for (int t = 0; t < 8; t++) begin
      tick;
      if (t < 3) in_data = vals[t+1];
      else in_valid = 1'b0;
      #1;
      if (t < 3) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready edge %0d got %0b want 1", t, in_ready); end
      end
      if (t >= 3 && t <= 6) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid edge %0d got %0b want 1", t, out_valid); end
        n_cmp++; if (out_data !== exp[t-3]) begin n_err++; $display("FAIL b2b_out_data edge %0d got %0d want %0d", t, out_data, exp[t-3]); end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_out_valid edge %0d got %0b want 0", t, out_valid); end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [39:0] exp [5];
    logic [2:0]  occ_exp [5];
    exp     = '{40'd32, 40'd243, 40'd1024, 40'd3125, 40'd7776};
    occ_exp = '{3'd4, 3'd4, 3'd3, 3'd2, 3'd1};
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready accept %0d got %0b want 1", i, in_ready); end
      tick;
      in_data = in_data + 8'd1;
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready cyc %0d got %0b want 0", i, in_ready); end
      n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_full_occupancy cyc %0d got %0d want 4", i, occupancy); end
      n_cmp++; if (out_data !== 40'd32 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold cyc %0d got v=%0b d=%0d want v=1 d=32", i, out_valid, out_data); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_full_ready_passthru got %0b want 1", in_ready); end
    for (int i = 1; i < 5; i++) begin
      tick;
      if (i == 1) in_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin n_err++; $display("FAIL bp_drain %0d got v=%0b d=%0d want v=1 d=%0d", i, out_valid, out_data, exp[i]); end
      n_cmp++; if (occupancy !== occ_exp[i]) begin n_err++; $display("FAIL bp_drain_occupancy %0d got %0d want %0d", i, occupancy, occ_exp[i]); end
    end
    tick;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_err++; $display("FAIL bp_empty got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_bubble;
    logic       iv  [8];
    logic [7:0] dat [8];
    logic [39:0] exp [4];
    iv  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    dat = '{8'd7, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd1, 8'd2};
    exp = '{40'd16807, 40'd243, 40'd1, 40'd32};
    out_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      in_valid = iv[t]; in_data = dat[t];
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bubble_in_ready cyc %0d got %0b want 1", t, in_ready); end
      tick;
    end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0 || occupancy !== 3'd4) begin n_err++; $display("FAIL bubble_full got rdy=%0b occ=%0d want rdy=0 occ=4", in_ready, occupancy); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin n_err++; $display("FAIL bubble_drain %0d got v=%0b d=%0d want v=1 d=%0d", i, out_valid, out_data, exp[i]); end
      tick;
    end
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_err++; $display("FAIL bubble_empty got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd9;
    for (int i = 0; i < 3; i++) tick;
    in_valid = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b1 || occupancy !== 3'd3) begin n_err++; $display("FAIL mid_loaded got v=%0b occ=%0d want v=1 occ=3", out_valid, occupancy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL mid_rst_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready got %0b want 1", in_ready); end
    tick;
    rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd2;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (i == 0) in_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== (i == 3)) begin n_err++; $display("FAIL mid_after_out_valid edge %0d got %0b want %0b", i, out_valid, (i == 3)); end
      if (i == 3) begin
        n_cmp++; if (out_data !== 40'd32) begin n_err++; $display("FAIL mid_after_out_data got %0d want 32", out_data); end
      end
    end
  endtask

  task automatic test_corner;
    c_out_ready = 1'b1; c_in_valid = 1'b1; c_in_data = 4'd15;
    #1;
    n_cmp++; if (c_in_ready !== 1'b1) begin n_err++; $display("FAIL corner_in_ready got %0b want 1", c_in_ready); end
    tick;
    c_in_data = 4'd3;
    #1;
    n_cmp++; if (c_out_valid !== 1'b1 || c_out_data !== 8'd225) begin n_err++; $display("FAIL corner_15 got v=%0b d=%0d want v=1 d=225", c_out_valid, c_out_data); end
    n_cmp++; if (c_occupancy !== 1'b1) begin n_err++; $display("FAIL corner_occupancy got %0d want 1", c_occupancy); end
    tick;
    c_in_data = 4'd2; c_out_ready = 1'b0;
    #1;
    n_cmp++; if (c_out_valid !== 1'b1 || c_out_data !== 8'd9) begin n_err++; $display("FAIL corner_3 got v=%0b d=%0d want v=1 d=9", c_out_valid, c_out_data); end
    n_cmp++; if (c_in_ready !== 1'b0) begin n_err++; $display("FAIL corner_full_in_ready got %0b want 0", c_in_ready); end
    tick;
    n_cmp++; if (c_out_data !== 8'd9 || c_occupancy !== 1'b1) begin n_err++; $display("FAIL corner_hold got d=%0d occ=%0d want d=9 occ=1", c_out_data, c_occupancy); end
    c_out_ready = 1'b1;
    #1;
    n_cmp++; if (c_in_ready !== 1'b1) begin n_err++; $display("FAIL corner_passthru got %0b want 1", c_in_ready); end
    tick;
    c_in_valid = 1'b0;
    #1;
    n_cmp++; if (c_out_valid !== 1'b1 || c_out_data !== 8'd4) begin n_err++; $display("FAIL corner_2 got v=%0b d=%0d want v=1 d=4", c_out_valid, c_out_data); end
    tick;
    n_cmp++; if (c_out_valid !== 1'b0 || c_occupancy !== 1'b0) begin n_err++; $display("FAIL corner_empty got v=%0b occ=%0d want 0/0", c_out_valid, c_occupancy); end
  endtask

  task automatic test_random;
    logic [39:0] q [$];
    logic [39:0] head;
    for (int cyc = 0; cyc < 406; cyc++) begin
      if (cyc < 400) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = 8'($urandom_range(0, 255));
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      n_cmp++; if (int'(occupancy) !== q.size()) begin n_err++; $display("FAIL rand_occupancy cyc %0d got %0d want %0d", cyc, occupancy, q.size()); end
      n_cmp++; if (in_ready !== (q.size() < 4 || out_ready)) begin n_err++; $display("FAIL rand_in_ready cyc %0d got %0b model_size %0d out_ready %0b", cyc, in_ready, q.size(), out_ready); end
      if (out_valid && q.size() == 0) begin
        n_cmp++; n_err++; $display("FAIL rand_spurious_output cyc %0d got d=%0d want no output", cyc, out_data);
      end else if (out_valid && out_ready) begin
        head = q.pop_front();
        n_cmp++; if (out_data !== head) begin n_err++; $display("FAIL rand_out_data cyc %0d got %0d want %0d", cyc, out_data, head); end
      end
      if (in_valid && in_ready) q.push_back(pow5(in_data));
      tick;
    end
    n_cmp++; if (q.size() != 0 || occupancy !== 3'd0) begin n_err++; $display("FAIL rand_drained got left=%0d occ=%0d want 0/0", q.size(), occupancy); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_bubble;
    test_reset_midflight;
    test_corner;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
